shift_pipe: RTL and testbench

Parametrised, pipelined successor to the single-cycle logical-right shifter in the execute stage. Supports logical-left, logical-right and arithmetic-right shifts, plus optional rotate, on a WIDTH-bit operand. Splits the log2(WIDTH) mux levels across PIPE_STAGES registered stages with valid/ready flow control, backpressure and flush. Carries a sideband tag so the issuing logic can match results to requests.

---
 rtl/shift_pkg.sv | 34 +++
 rtl/shift_pipe_level.sv | 41 ++++
 rtl/shift_pipe.sv | 177 +++++++++++++++++
 tb/tb_shift_pipe.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shift_pkg
// Description : Shared types and helpers for the pipelined shifter:
//               shift opcode enum, default operand width, bit-reverse helper.
// Revision    : 1.0 - initial release
// ============================================================================
package shift_pkg;

  localparam int DEFAULT_WIDTH = 32;

  // Widest operand the bit-reverse helper handles; must exceed WIDTH.
  localparam int SHIFT_MAX_W = 256;

  typedef enum logic [1:0] {
    SHIFT_SLL = 2'b00,
    SHIFT_SRL = 2'b01,
    SHIFT_SRA = 2'b10,
    SHIFT_ROR = 2'b11
  } shift_op_e;

  // Reverse the low w bits of x; bits at and above w come back as zero.
  function automatic logic [SHIFT_MAX_W-1:0] bitrev(input logic [SHIFT_MAX_W-1:0] x,
                                                    input int w);
    logic [SHIFT_MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < SHIFT_MAX_W; i++) begin
      if (i < w) r[i] = x[w-1-i];
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/shift_pipe_level.sv
`default_nettype none
// ============================================================================
// Module      : shift_level
// Description : One combinational right-shift mux level of distance DIST.
//               Vacated MSBs take the fill bit, or the shifted-out LSBs when
//               rotating (rotate path only with SHIFT_PIPE_ROTATE_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module shift_level #(
  parameter int WIDTH = 32,
  parameter int DIST  = 1
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic             en,
  input  logic             fill,
  input  logic             rot,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] shifted;

`ifdef SHIFT_PIPE_ROTATE_EN
  // Rotate wraps the low DIST bits to the top; otherwise fill from the left.
  always_comb begin
    shifted = {{DIST{fill}}, data_i[WIDTH-1:DIST]};
    if (rot) shifted = {data_i[DIST-1:0], data_i[WIDTH-1:DIST]};
  end
`else
  // No wrap path: rotate requests degrade to a plain fill shift.
  logic unused_rot;
  assign unused_rot = rot;

  always_comb begin
    shifted = {{DIST{fill}}, data_i[WIDTH-1:DIST]};
  end
`endif

  assign data_o = en ? shifted : data_i;

endmodule
`default_nettype wire

// File: rtl/shift_pipe.sv
`default_nettype none
// ============================================================================
// Module      : shift_pipe
// Description : Pipelined SLL/SRL/SRA/(ROR) shifter. The log2(WIDTH) mux
//               levels are spread over PIPE_STAGES registered stages with
//               collapsing valid/ready flow control, flush and a sideband tag.
//               Build option: SHIFT_PIPE_ROTATE_EN enables ROR for op 2'b11;
//               without it op 2'b11 behaves as SRL.
//               WIDTH must be below shift_pkg::SHIFT_MAX_W.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_pipe
  import shift_pkg::*;
#(
  parameter  int WIDTH       = DEFAULT_WIDTH,
  parameter  int PIPE_STAGES = 2,
  parameter  int TAG_W       = 4,
  localparam int SHAMT_W     = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_op,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int S = PIPE_STAGES;

  // Stage registers
  logic [S-1:0]       v_q, v_d;
  logic [S-1:0]       fill_q, fill_d;
  logic [WIDTH-1:0]   data_q  [S];
  logic [WIDTH-1:0]   data_d  [S];
  logic [SHAMT_W-1:0] shamt_q [S];
  logic [SHAMT_W-1:0] shamt_d [S];
  shift_op_e          op_q    [S];
  shift_op_e          op_d    [S];
  logic [TAG_W-1:0]   tag_q   [S];
  logic [TAG_W-1:0]   tag_d   [S];

  // What each stage consumes: entry logic for stage 0, previous register else
  logic [S-1:0]       src_v, src_fill;
  logic [WIDTH-1:0]   src_data  [S];
  logic [SHAMT_W-1:0] src_shamt [S];
  shift_op_e          src_op    [S];
  logic [TAG_W-1:0]   src_tag   [S];

  logic [WIDTH-1:0]   stg_res [S];
  logic [WIDTH-1:0]   lvl_in  [SHAMT_W];
  logic [WIDTH-1:0]   lvl_out [SHAMT_W];
  logic [S-1:0]       rdy;

  shift_op_e          in_op_e;
  logic [SHIFT_MAX_W-1:0] ent_rev, out_rev;

  assign in_op_e = shift_op_e'(in_op);
  // Left shifts run through the right-shift levels on a bit-reversed operand.
  assign ent_rev = bitrev(SHIFT_MAX_W'(in_data), WIDTH);
  assign out_rev = bitrev(SHIFT_MAX_W'(stg_res[S-1]), WIDTH);

  // Select each stage's source: the request port or the preceding register.
  always_comb begin
    src_v[0]     = in_valid;
    src_data[0]  = (in_op_e == SHIFT_SLL) ? ent_rev[WIDTH-1:0] : in_data;
    src_shamt[0] = in_shamt;
    src_op[0]    = in_op_e;
    src_fill[0]  = (in_op_e == SHIFT_SRA) & in_data[WIDTH-1];
    src_tag[0]   = in_tag;
    for (int s = 1; s < S; s++) begin
      src_v[s]     = v_q[s-1];
      src_data[s]  = data_q[s-1];
      src_shamt[s] = shamt_q[s-1];
      src_op[s]    = op_q[s-1];
      src_fill[s]  = fill_q[s-1];
      src_tag[s]   = tag_q[s-1];
    end
  end

  // Mux level k lives in stage k*S/SHAMT_W; levels of one stage chain directly.
  for (genvar k = 0; k < SHAMT_W; k++) begin : g_level
    localparam int  STG   = (k * S) / SHAMT_W;
    localparam bit  FIRST = (k == 0) || ((((k - 1) * S) / SHAMT_W) != STG);
    localparam bit  LAST  = (k == SHAMT_W - 1) || ((((k + 1) * S) / SHAMT_W) != STG);

    if (FIRST) begin : g_first
      assign lvl_in[k] = src_data[STG];
    end else begin : g_chain
      assign lvl_in[k] = lvl_out[k-1];
    end

    shift_level #(
      .WIDTH (WIDTH),
      .DIST  (1 << k)
    ) u_level (
      .data_i (lvl_in[k]),
      .en     (src_shamt[STG][k]),
      .fill   (src_fill[STG]),
      .rot    (src_op[STG] == SHIFT_ROR),
      .data_o (lvl_out[k])
    );

    if (LAST) begin : g_last
      assign stg_res[STG] = lvl_out[k];
    end
  end

  // Ready chain back to front, then per-stage load/hold and flush.
  always_comb begin
    rdy[S-1] = out_ready | ~v_q[S-1];
    for (int s = S - 2; s >= 0; s--) rdy[s] = rdy[s+1] | ~v_q[s];

    v_d    = v_q;
    fill_d = fill_q;
    for (int s = 0; s < S; s++) begin
      data_d[s]  = data_q[s];
      shamt_d[s] = shamt_q[s];
      op_d[s]    = op_q[s];
      tag_d[s]   = tag_q[s];
      if (rdy[s]) begin
        v_d[s] = src_v[s];
        if (src_v[s]) begin
          data_d[s]  = stg_res[s];
          shamt_d[s] = src_shamt[s];
          op_d[s]    = src_op[s];
          fill_d[s]  = src_fill[s];
          tag_d[s]   = src_tag[s];
          // Undo the entry reversal before the output register.
          if ((s == S - 1) && (src_op[s] == SHIFT_SLL)) data_d[s] = out_rev[WIDTH-1:0];
        end
      end
    end
    if (flush) v_d = '0;
  end

  // Stage registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q    <= '0;
      fill_q <= '0;
      for (int s = 0; s < S; s++) begin
        data_q[s]  <= '0;
        shamt_q[s] <= '0;
        op_q[s]    <= SHIFT_SLL;
        tag_q[s]   <= '0;
      end
    end else begin
      v_q    <= v_d;
      fill_q <= fill_d;
      for (int s = 0; s < S; s++) begin
        data_q[s]  <= data_d[s];
        shamt_q[s] <= shamt_d[s];
        op_q[s]    <= op_d[s];
        tag_q[s]   <= tag_d[s];
      end
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = v_q[S-1];
  assign out_data  = data_q[S-1];
  assign out_tag   = tag_q[S-1];

  // Last-stage control fields and helper padding bits have no consumer.
  logic unused_bits;
  assign unused_bits = ^{shamt_q[S-1], fill_q[S-1], op_q[S-1],
                         ent_rev[SHIFT_MAX_W-1:WIDTH], out_rev[SHIFT_MAX_W-1:WIDTH]};

endmodule
`default_nettype wire

// File: tb/tb_shift_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_pipe
// Description : Self-checking bench for shift_pipe (WIDTH=32, PIPE_STAGES=2).
//               Honours SHIFT_PIPE_ROTATE_EN for the op 2'b11 expectation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_pipe;

  localparam int W  = 32;
  localparam int S  = 2;
  localparam int TW = 4;
  localparam int SW = 5;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b1;
  logic          flush     = 1'b0;
  logic          in_valid  = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data   = '0;
  logic [SW-1:0] in_shamt  = '0;
  logic [1:0]    in_op     = '0;
  logic [TW-1:0] in_tag    = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_data;
  logic [TW-1:0] out_tag;

  shift_pipe #(.WIDTH(W), .PIPE_STAGES(S), .TAG_W(TW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_op     (in_op),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int n_out  = 0;
  int last_stall = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain shift operators on the whole word.
  function automatic logic [W-1:0] ref_shift(input logic [W-1:0] d, input int sh, input int op);
    logic [W-1:0] r;
    case (op)
      0: r = d << sh;
      1: r = d >> sh;
      2: r = W'($signed(d) >>> sh);
      default: begin
`ifdef SHIFT_PIPE_ROTATE_EN
        r = (sh == 0) ? d : ((d >> sh) | (d << (W - sh)));
`else
        r = d >> sh;
`endif
      end
    endcase
    return r;
  endfunction

  typedef struct {
    logic [W-1:0]  data;
    logic [TW-1:0] tag;
    int            cyc;
  } exp_t;

  exp_t sbq[$];
  logic         hold_prev = 1'b0;
  logic [W-1:0] prev_data;
  logic [TW-1:0] prev_tag;

  // Scoreboard: every accepted request must come out in order, correct, with
  // latency 2 unless the output stalled since it was accepted; held outputs
  // must not change.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sbq.delete();
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, prev_data);
        chk("hold_tag", out_tag, prev_tag);
      end
      if (!out_ready) last_stall = cyc;
      if (out_valid && out_ready) begin
        n_out++;
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got tag %0h data %0h with nothing outstanding", out_tag, out_data);
        end else begin
          e = sbq.pop_front();
          chk("sb_data", out_data, e.data);
          chk("sb_tag", out_tag, e.tag);
          if (last_stall < e.cyc) chk("sb_latency", cyc - e.cyc, 2);
        end
      end
      if (flush) sbq.delete();
      else if (in_valid && in_ready)
        sbq.push_back('{ref_shift(in_data, int'(in_shamt), int'(in_op)), in_tag, cyc});
      hold_prev = out_valid && !out_ready && !flush;
      prev_data = out_data;
      prev_tag  = out_tag;
    end
  end

  task automatic send_one(input logic [W-1:0] d, input int sh, input int op,
                          input logic [TW-1:0] tag, input logic [W-1:0] exp, input string nm);
    int k;
    @(posedge clk); #1;
    out_ready = 1'b1; in_valid = 1'b1; in_data = d;
    in_shamt = SW'(sh); in_op = 2'(op); in_tag = tag;
    @(negedge clk);
    chk({nm, "_in_ready"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    k = 1;
    while (k < 10) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk);
      k++;
    end
    chk({nm, "_valid"}, out_valid, 1);
    chk({nm, "_latency"}, k, 2);
    chk({nm, "_data"}, out_data, exp);
    chk({nm, "_tag"}, out_tag, tag);
  endtask

  task automatic wait_drain(input int bound);
    int k;
    k = 0;
    while ((sbq.size() != 0 || out_valid) && k < bound) begin
      @(negedge clk);
      k++;
    end
    chk("drain_timeout", (k < bound) ? 1 : 0, 1);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int base;
    logic [W-1:0] exp_a;

    // Reset state
    #1 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    // Directed single ops with literal results
    send_one(32'h8000_00F0, 4, 2, 4'h5, 32'hF800_000F, "sra4");
    send_one(32'h8000_00F0, 4, 1, 4'h6, 32'h0800_000F, "srl4");
    send_one(32'h8000_00F0, 4, 0, 4'h7, 32'h0000_0F00, "sll4");
    send_one(32'h8000_00F0, 0, 2, 4'h8, 32'h8000_00F0, "sra0");
    send_one(32'hDEAD_BEEF, 31, 0, 4'h9, 32'h8000_0000, "sll31");
    send_one(32'h8000_0000, 31, 2, 4'hA, 32'hFFFF_FFFF, "sra31");
`ifdef SHIFT_PIPE_ROTATE_EN
    send_one(32'h0000_0001, 1, 3, 4'hB, 32'h8000_0000, "ror1");
`else
    send_one(32'h0000_0001, 1, 3, 4'hB, 32'h0000_0000, "ror1");
`endif
    wait_drain(10);

    // Back-to-back streaming, out_ready held high
    base = n_out;
    for (int i = 0; i < 64; i++) begin
      @(posedge clk); #1;
      out_ready = 1'b1; in_valid = 1'b1; in_data = $urandom;
      in_shamt = SW'($urandom_range(0, 31)); in_op = 2'($urandom_range(0, 3)); in_tag = TW'(i);
    end
    @(posedge clk); #1 in_valid = 1'b0;
    wait_drain(20);
    chk("stream_count", n_out - base, 64);

    // Backpressure: fill both stages, stall 5 cycles, release
    base = n_out;
    exp_a = ref_shift(32'h1234_5678, 8, 1);
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h1234_5678; in_shamt = 5'd8; in_op = 2'd1; in_tag = 4'h1;
    @(posedge clk); #1;
    in_data = 32'hF000_0001; in_shamt = 5'd3; in_op = 2'd2; in_tag = 4'h2;
    @(posedge clk); #1;
    in_data = 32'h0000_00FF; in_shamt = 5'd4; in_op = 2'd0; in_tag = 4'h3;
    repeat (5) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_data", out_data, exp_a);
      chk("bp_out_tag", out_tag, 4'h1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_in_ready", in_ready, 1);
    @(posedge clk); #1 in_valid = 1'b0;
    wait_drain(10);
    chk("bp_count", n_out - base, 3);

    // Flush with two in flight plus a new request
    base = n_out;
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hAAAA_5555; in_shamt = 5'd1; in_op = 2'd1; in_tag = 4'hC;
    @(posedge clk); #1;
    in_tag = 4'hD;
    @(posedge clk); #1;
    in_tag = 4'hE; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    @(posedge clk); #1 out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1 chk("flush_count", n_out - base, 0);

    // Random traffic with random backpressure and occasional flush
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (!in_valid || in_ready || flush) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = $urandom;
        in_shamt = SW'($urandom_range(0, 31));
        in_op    = 2'($urandom_range(0, 3));
        in_tag   = TW'($urandom);
      end
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 39) == 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    wait_drain(10);

    // Asynchronous reset in mid-stream
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_data = $urandom; in_shamt = SW'($urandom_range(0, 31));
      in_op = 2'($urandom_range(0, 3)); in_tag = TW'(i);
    end
    @(posedge clk); #3;
    rst_n = 1'b0; in_valid = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_data", out_data, 0);
    chk("arst_out_tag", out_tag, 0);
    chk("arst_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    chk("arst_idle_valid", out_valid, 0);
    send_one(32'h0F0F_0F0F, 16, 1, 4'h4, 32'h0000_0F0F, "post_rst");
    wait_drain(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
